// File: rtl/puzzle_pkg.sv
// Shared types and constants for the 8-puzzle button front end.
package puzzle_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    PRESSED,
    RELEASING
  } btn_state_t;

  localparam int PRESS_COUNT_W = 8;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for a raw asynchronous level; reused for any raw input.
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/btn_press_detector.sv
// Debounced push-button front end: one press pulse per accepted press, level and press count.
// Optional auto-repeat while held is compiled in with `define BTN_AUTOREPEAT_EN.
//
// state     | meaning
// IDLE      | button released and stable
// ARMING    | btn_s high, counting towards acceptance
// PRESSED   | press accepted, button held
// RELEASING | btn_s low, counting towards release
module btn_press_detector
  import puzzle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     btn,
  output logic                     press,
  output logic                     level,
  output logic [PRESS_COUNT_W-1:0] press_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("btn_press_detector: parameter out of range");
  end

  btn_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             btn_s;
  logic             accept;
  logic             rep_fire;
  logic             pulse_nxt;
  logic             level_nxt;

  btn_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (btn),
    .sync_out (btn_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = ARMING;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = '0;
        end
      end
      ARMING: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nxt = RELEASING;
          cnt_nxt   = CNT_ONE;
        end
      end
      RELEASING: begin
        // A high sample here is release bounce: fall back without a new pulse.
        if (btn_s) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX < 2) ? 1 : $clog2(REP_MAX);
  localparam logic [REP_W-1:0] REP_DLY_LD = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PER_LD = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             hold;

  assign hold     = (state == PRESSED) && (state_nxt == PRESSED);
  assign rep_fire = hold && (rep_cnt == '0);

  // Down-counter to the next repeat; reloaded with the delay on every entry to PRESSED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (state_nxt == PRESSED && state != PRESSED) begin
      rep_cnt <= REP_DLY_LD;
    end else if (hold) begin
      rep_cnt <= rep_fire ? REP_PER_LD : rep_cnt - REP_W'(1);
    end else begin
      rep_cnt <= '0;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    accept    = (state == ARMING) && btn_s && (cnt == CNT_LAST);
    pulse_nxt = accept || rep_fire;
    level_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press       <= 1'b0;
      level       <= 1'b0;
      press_count <= '0;
    end else begin
      press <= pulse_nxt;
      level <= level_nxt;
      if (pulse_nxt) begin
        press_count <= press_count + PRESS_COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_btn_press_detector.sv
// Directed self-checking bench for btn_press_detector (DEBOUNCE_CYCLES=8).
module tb_btn_press_detector;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic       press;
  logic       level;
  logic [7:0] press_count;

  int n_checks = 0;
  int n_errors = 0;
  int ncyc     = 0;
  int npress   = 0;
  int press_t[$];

  btn_press_detector #(
    .DEBOUNCE_CYCLES (8),
    .REPEAT_DELAY    (64),
    .REPEAT_PERIOD   (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (btn),
    .press       (press),
    .level       (level),
    .press_count (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (press) begin
      npress <= npress + 1;
      press_t.push_back(ncyc + 1);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    btn   = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
  endtask

  int p0;
  int base;
  int bad;
  int lv;
  int exp_cnt;
  int exp_t[$];

  initial begin
    btn   = 1'b0;
    rst_n = 1'b0;
    step(3);
    chk("rst_press", press, 0);
    chk("rst_level", level, 0);
    chk("rst_count", press_count, 0);
    rst_n = 1'b1;

    // Idle for 100 cycles
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (press || level || press_count != 0) bad = 1;
    end
    chk("idle100", bad, 0);

    // 10-cycle pulse: press visible 10 cycles after btn rises, level falls 10 after it drops
    p0 = npress;
    btn = 1'b1;
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      step(1);
      if (press || level) bad = 1;
    end
    chk("pulse_early", bad, 0);
    step(1);
    chk("pulse_press", press, 1);
    chk("pulse_level", level, 1);
    btn = 1'b0;
    step(9);
    chk("rel_hold_level", level, 1);
    step(1);
    chk("rel_done_level", level, 0);
    chk("pulse_npress", npress - p0, 1);
    chk("pulse_count", press_count, 1);

    // 5-cycle pulse and per-cycle toggling must both be rejected
    apply_reset();
    chk("rst2_count", press_count, 0);
    p0 = npress;
    lv = 0;
    btn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      lv |= int'(level);
    end
    btn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      lv |= int'(level);
    end
    chk("short_npress", npress - p0, 0);
    chk("short_level", lv, 0);
    for (int i = 0; i < 40; i++) begin
      btn = ~btn;
      step(1);
      lv |= int'(level);
    end
    btn = 1'b0;
    step(12);
    chk("toggle_npress", npress - p0, 0);
    chk("toggle_level", lv, 0);
    chk("toggle_count", press_count, 0);

    // Release with three one-cycle bounce glitches
    exp_cnt = 0;
    p0 = npress;
    btn = 1'b1;
    step(12);
    exp_cnt++;
    chk("bounce_acc_level", level, 1);
    lv = 1;
    for (int g = 0; g < 3; g++) begin
      btn = 1'b0;
      step(2);
      lv &= int'(level);
      btn = 1'b1;
      step(1);
      lv &= int'(level);
    end
    btn = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(1);
      lv &= int'(level);
    end
    chk("bounce_level_held", lv, 1);
    step(1);
    chk("bounce_level_drop", level, 0);
    chk("bounce_npress", npress - p0, 1);
    chk("bounce_count", press_count, exp_cnt);

    // 256 clean presses wrap the counter
    apply_reset();
    p0 = npress;
    exp_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      btn = 1'b1;
      step(10);
      btn = 1'b0;
      step(12);
      exp_cnt = (exp_cnt + 1) % 256;
      if (i == 254) chk("wrap_count_255", press_count, 255);
    end
    chk("wrap_count_0", press_count, exp_cnt);
    chk("wrap_npress", npress - p0, 256);

    // Reset while ARMING, then a still-held button needs a full debounce
    btn = 1'b1;
    step(10);
    btn = 1'b0;
    step(12);
    chk("pre_rst_count", press_count, 1);
    p0 = npress;
    btn = 1'b1;
    step(5);
    rst_n = 1'b0;
    #1;
    chk("arm_rst_press", press, 0);
    chk("arm_rst_level", level, 0);
    chk("arm_rst_count", press_count, 0);
    step(2);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      step(1);
      if (press || level) bad = 1;
    end
    chk("arm_rst_early", bad, 0);
    step(1);
    chk("arm_rst_press_new", press, 1);
    chk("arm_rst_count_new", press_count, 1);
    btn = 1'b0;
    step(12);
    chk("arm_rst_npress", npress - p0, 1);

    // Long hold: auto-repeat pulses when compiled in, a single pulse otherwise
    apply_reset();
    press_t.delete();
    base = ncyc;
    btn = 1'b1;
    step(130);
    btn = 1'b0;
    step(12);
`ifdef BTN_AUTOREPEAT_EN
    exp_t = '{10, 74, 90, 106, 122};
`else
    exp_t = '{10};
`endif
    chk("hold_npulses", press_t.size(), exp_t.size());
    for (int i = 0; i < exp_t.size(); i++) begin
      chk($sformatf("hold_pulse%0d", i),
          (i < press_t.size()) ? press_t[i] - base : -1, exp_t[i]);
    end
    chk("hold_count", press_count, exp_t.size());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
